conv_pool_layer: RTL and testbench
==================================

// Module: conv_pool_layer
// PURPOSE
//  Parametrised binary-input conv layer with fused 2x2/stride-2 max-pool readout.
//  Accumulates TAPS serial 1-bit pixels per output pixel across CH channels, adds
//  bias, applies ReLU, stores into per-channel FM_W x FM_W feature RAM, then streams
//  pooled windows over valid/ready to the next layer. Weights/bias are loaded at run time.
// PARAMETERS
//  CH    2   output channels
//  TAPS  9   kernel taps (input bits) per output pixel
//  FM_W  26  feature-map width = height; must be even
//  WW    9   signed weight/bias width
//  AW    18  signed accumulator/output width per channel
// PORTS
//  clk        in   1             clock; all logic on posedge
//  rst        in   1             asynchronous reset, active-high
//  frame_clr  in   1             sync clear of frame state; weights kept
//  wt_we      in   1             weight/bias write strobe
//  wt_ch      in   $clog2(CH)    channel select for write
//  wt_tap     in   $clog2(TAPS+1) tap index; value TAPS selects bias
//  wt_data    in   WW            signed weight/bias value
//  in_vld     in   1             din valid
//  in_rdy     out  1             block accepts din
//  din        in   1             binary pixel: 1 -> +weight, 0 -> 0
//  out_vld    out  1             pooled word valid
//  out_rdy    in   1             downstream accepts pooled word
//  out_data   out  CH*AW         pooled values, ch0 in [AW-1:0]
//  frame_done out  1             1-cycle pulse after last pooled word taken
// BEHAVIOUR
//  Reset: in_rdy=1, out_vld=0, out_data=0, frame_done=0; all counters and FSMs
//   cleared; weight/bias RAM contents undefined.
//  Write side: tap_cnt 0..TAPS-1 advances on in_vld&&in_rdy; acc += din ? sext(w[ch][tap]) : 0.
//   tap_cnt==0 starts acc from 0. On the edge accepting tap TAPS-1, pixel =
//   acc + product + sext(bias); ReLU with signed compare (<=0 -> 0); written at wr_cnt;
//   wr_cnt++. No bubble between pixels.
//  Arithmetic wraps mod 2^AW (see CONFIGURATION).
//  in_rdy=0 once wr_cnt==FM_W*FM_W until frame_clr.
//  wt_we is ignored when tap_cnt!=0; otherwise writes the next edge.
//  Read FSM: IDLE, R0, R1, R2, R3, CMP, HOLD, DONE.
//   Window base a starts at FM_W+1.
//   IDLE->R0 when wr_cnt > a; R0..R3 issue a-FM_W-1, a-FM_W, a-1, a.
//   The RAM has 1-cycle read latency, and a running max per channel is kept.
//   CMP folds the last word into the max, then HOLD.
//   HOLD: out_vld=1, out_data stable until out_rdy.
//   On accept: a += 2, or a += FM_W+2 at the end of a pooled row.
//   On accept of the last window (a==FM_W*FM_W-1): go to DONE and pulse frame_done.
//   Otherwise return to IDLE. DONE waits for frame_clr.
//  Latency: window ready -> out_vld = 5 cycles. Writer and reader run concurrently
//   with dual-port RAM; a read never overtakes the write pointer.
//  frame_clr (any state): tap_cnt, acc, wr_cnt, a cleared; FSM->IDLE; out_vld=0 next
//   cycle; in-flight pixel/window discarded. frame_clr has priority over in_vld and wt_we.
//  Simultaneous accept of the last pixel and a pending window compare: wr_cnt
//   update is seen by the reader the following cycle.
// CONFIGURATION
//  CONV_SAT_EN defined: acc and bias add saturate to [-2^(AW-1), 2^(AW-1)-1].
//  Undefined: two's-complement wrap. ReLU follows in both cases.
// TESTING
//  All weights=1, bias=-4, din=1 for all taps -> every pixel 5; every out_data channel=5;
//   169 words, then frame_done.
//  ch0 bias=-20, weights=1 -> all ch0 pixels 0 (ReLU); ch1 bias=+3 -> 3.
//  Distinct pixel values: pool of {1,7,2,3} -> 7; the first window uses addrs 0,1,26,27.
//  out_rdy low 20 cycles in HOLD -> out_data/out_vld stable; writer continues
//   until the frame is full.
//  frame_clr mid-window and mid-pixel -> out_vld 0 next cycle; a new frame gives correct first word.
//  AW=10, weights=+255, bias=+255, din=1 -> wraps without CONV_SAT_EN; 511 with it.

Source files
------------

// File: rtl/conv_pool_layer.sv
// conv_pool_layer: serial binary conv + bias + ReLU into feature RAM, streamed out as 2x2/stride-2 max-pool windows.
// Define CONV_SAT_EN for saturating accumulation; otherwise arithmetic wraps.
module conv_pool_layer #(
  parameter int CH   = 2,
  parameter int TAPS = 9,
  parameter int FM_W = 26,
  parameter int WW   = 9,
  parameter int AW   = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_clr,
  input  logic                        wt_we,
  input  logic [$clog2(CH)-1:0]       wt_ch,
  input  logic [$clog2(TAPS+1)-1:0]   wt_tap,
  input  logic [WW-1:0]               wt_data,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic                        din,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [CH*AW-1:0]            out_data,
  output logic                        frame_done
);
  localparam int N  = FM_W * FM_W;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TAPS + 1);
  localparam int PW = $clog2(FM_W);
  typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, CMP, HOLD, DONE} state_t;
  function automatic logic [AW-1:0] add_f(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] s;
    s = x + y;
`ifdef CONV_SAT_EN
    if (x[AW-1] == y[AW-1] && s[AW-1] != x[AW-1]) s = {x[AW-1], {(AW-1){~x[AW-1]}}};
`endif
    return s;
  endfunction
  function automatic logic [AW-1:0] sext(input logic [WW-1:0] w);
    return {{(AW-WW){w[WW-1]}}, w};
  endfunction
  logic [WW-1:0] wt_mem [CH][TAPS+1];
  logic [CH-1:0][AW-1:0] fm_mem [N];
  logic [CH-1:0][AW-1:0] acc_q, acc_d, sum, pix, max_q, max_d, fold, rd_data;
  logic [TW-1:0] tap_cnt_q, tap_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, a_q, a_d, rd_addr;
  logic [PW-1:0] col_q, col_d;
  logic frame_done_q, frame_done_d, acc_fire, last_tap;
  state_t st_q, st_d;
  assign in_rdy     = wr_cnt_q != CW'(N);
  assign acc_fire   = in_vld && in_rdy && !frame_clr;
  assign last_tap   = tap_cnt_q == TW'(TAPS - 1);
  assign out_vld    = st_q == HOLD;
  assign out_data   = max_q;
  assign frame_done = frame_done_q;
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum[c]  = add_f(tap_cnt_q == '0 ? '0 : acc_q[c], din ? sext(wt_mem[c][tap_cnt_q]) : '0);
      pix[c]  = add_f(sum[c], sext(wt_mem[c][TAPS]));
      pix[c]  = pix[c][AW-1] ? '0 : pix[c];
      fold[c] = $signed(rd_data[c]) > $signed(max_q[c]) ? rd_data[c] : max_q[c];
    end
    tap_cnt_d = frame_clr ? '0 : acc_fire ? (last_tap ? '0 : tap_cnt_q + TW'(1)) : tap_cnt_q;
    acc_d     = frame_clr ? '0 : acc_fire ? sum : acc_q;
    wr_cnt_d  = frame_clr ? '0 : (acc_fire && last_tap) ? wr_cnt_q + CW'(1) : wr_cnt_q;
  end
  // Read data lags the issued address by one cycle, so R1 sees the R0 word.
  always_comb begin
    st_d         = st_q;
    a_d          = a_q;
    col_d        = col_q;
    max_d        = max_q;
    frame_done_d = 1'b0;
    rd_addr      = a_q;
    case (st_q)
      IDLE: st_d = wr_cnt_q > a_q ? R0 : IDLE;
      R0:   begin rd_addr = a_q - CW'(FM_W + 1); st_d = R1; end
      R1:   begin rd_addr = a_q - CW'(FM_W); max_d = rd_data; st_d = R2; end
      R2:   begin rd_addr = a_q - CW'(1); max_d = fold; st_d = R3; end
      R3:   begin max_d = fold; st_d = CMP; end
      CMP:  begin max_d = fold; st_d = HOLD; end
      HOLD: if (out_rdy) begin
        st_d         = a_q == CW'(N - 1) ? DONE : IDLE;
        frame_done_d = a_q == CW'(N - 1);
        a_d          = a_q + (col_q == PW'(FM_W/2 - 1) ? CW'(FM_W + 2) : CW'(2));
        col_d        = col_q == PW'(FM_W/2 - 1) ? '0 : col_q + PW'(1);
      end
      DONE: st_d = DONE;
      default: st_d = IDLE;
    endcase
    if (frame_clr) begin
      st_d         = IDLE;
      a_d          = CW'(FM_W + 1);
      col_d        = '0;
      max_d        = '0;
      frame_done_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wt_we && !frame_clr && tap_cnt_q == '0 && wt_tap <= TW'(TAPS)) wt_mem[wt_ch][wt_tap] <= wt_data;
    if (acc_fire && last_tap) fm_mem[wr_cnt_q] <= pix;
    rd_data <= fm_mem[rd_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= IDLE;
      tap_cnt_q    <= '0;
      acc_q        <= '0;
      wr_cnt_q     <= '0;
      a_q          <= CW'(FM_W + 1);
      col_q        <= '0;
      max_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      tap_cnt_q    <= tap_cnt_d;
      acc_q        <= acc_d;
      wr_cnt_q     <= wr_cnt_d;
      a_q          <= a_d;
      col_q        <= col_d;
      max_q        <= max_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_conv_pool_layer.sv
// tb_conv_pool_layer: directed frames checked against a pixel/pool model, plus a narrow-accumulator instance.
module tb_conv_pool_layer;
  localparam int CH = 2, TAPS = 9, FM_W = 26, WW = 9, AW = 18;
  localparam int N = FM_W * FM_W, NW = N / 4;
  logic clk = 0, rst = 1, frame_clr = 0, wt_we = 0, in_vld = 0, din = 0, out_rdy = 0;
  logic [0:0] wt_ch = '0;
  logic [3:0] wt_tap = '0;
  logic [WW-1:0] wt_data = '0;
  logic in_rdy, out_vld, frame_done;
  logic [CH*AW-1:0] out_data;
  logic s_clr = 0, s_we = 0, s_in_vld = 0, s_din = 0, s_out_rdy = 0;
  logic [0:0] s_ch = '0;
  logic [3:0] s_tap = '0;
  logic [WW-1:0] s_data = '0;
  logic s_in_rdy, s_out_vld, s_frame_done;
  logic [19:0] s_out_data;
  conv_pool_layer #(.CH(CH), .TAPS(TAPS), .FM_W(FM_W), .WW(WW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .wt_we(wt_we), .wt_ch(wt_ch), .wt_tap(wt_tap),
    .wt_data(wt_data), .in_vld(in_vld), .in_rdy(in_rdy), .din(din), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .frame_done(frame_done));
  conv_pool_layer #(.CH(2), .TAPS(9), .FM_W(2), .WW(9), .AW(10)) dut_s (
    .clk(clk), .rst(rst), .frame_clr(s_clr), .wt_we(s_we), .wt_ch(s_ch), .wt_tap(s_tap),
    .wt_data(s_data), .in_vld(s_in_vld), .in_rdy(s_in_rdy), .din(s_din), .out_vld(s_out_vld),
    .out_rdy(s_out_rdy), .out_data(s_out_data), .frame_done(s_frame_done));
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, mode = 1, got = 0;
  int wm [CH][TAPS+1];
  logic [CH*AW-1:0] exp_q [$];
  logic [CH*AW-1:0] mon_e;
  longint first_word = -1;
  logic fd_pend = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic longint addm(input longint x, input longint y, input int aw);
    longint s, h;
    s = x + y;
    h = longint'(1) << (aw - 1);
`ifdef CONV_SAT_EN
    return s > h - 1 ? h - 1 : (s < -h ? -h : s);
`else
    s = s & ((h << 1) - 1);
    return s >= h ? s - (h << 1) : s;
`endif
  endfunction
  function automatic int vbyte(input int p);
    return p == 0 ? 1 : p == 1 ? 7 : p == 26 ? 2 : p == 27 ? 3 : (p * 37 + 11) % 256;
  endfunction
  function automatic bit din_f(input int p, input int t);
    return mode != 3 || t >= 8 || ((vbyte(p) >> t) & 1) != 0;
  endfunction
  function automatic longint pix_m(input int p, input int c);
    longint acc = 0;
    for (int t = 0; t < TAPS; t++) acc = addm(acc, din_f(p, t) ? longint'(wm[c][t]) : 0, AW);
    acc = addm(acc, wm[c][TAPS], AW);
    return acc < 0 ? 0 : acc;
  endfunction
  task automatic build_exp();
    logic [CH*AW-1:0] w;
    longint m, v;
    exp_q.delete();
    for (int r = 0; r < FM_W / 2; r++)
      for (int q = 0; q < FM_W / 2; q++) begin
        w = '0;
        for (int c = 0; c < CH; c++) begin
          m = 0;
          for (int d = 0; d < 4; d++) begin
            v = pix_m((2 * r + d / 2) * FM_W + 2 * q + d % 2, c);
            m = v > m ? v : m;
          end
          w |= (CH*AW)'(m) << (c * AW);
        end
        exp_q.push_back(w);
      end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("frame_done", frame_done, fd_pend);
    fd_pend = 0;
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_word: got %0d expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("word%0d", got), out_data, mon_e);
        if (got == 0) first_word = out_data;
        got++;
        if (got == NW) fd_pend = 1;
      end
    end
  end
  task tick; @(posedge clk); #1; endtask
  task automatic clr_pulse(input bit vld);
    in_vld = vld; din = 1; frame_clr = 1;
    tick;
    frame_clr = 0; in_vld = 0;
  endtask
  task automatic load_all();
    for (int c = 0; c < CH; c++)
      for (int t = 0; t <= TAPS; t++) begin
        wt_we = 1; wt_ch = 1'(c); wt_tap = 4'(t); wt_data = WW'(wm[c][t]);
        tick;
        wt_we = 0;
      end
  endtask
  task automatic drive_tap(input bit b);
    bit ok;
    int k = 0;
    in_vld = 1; din = b;
    do begin ok = in_rdy; tick; k++; end while (!ok && k < 100);
    if (!ok) begin
      $display("FAIL drive_tap: in_rdy stuck low");
      $fatal(1);
    end
  endtask
  task automatic drive_pix(input int np, input int xt);
    for (int p = 0; p < np; p++)
      for (int t = 0; t < TAPS; t++) drive_tap(din_f(p, t));
    for (int t = 0; t < xt; t++) drive_tap(din_f(np, t));
    in_vld = 0;
  endtask
  task automatic run_frame(input bit stall, input longint fw);
    int k = 0;
    clr_pulse(0);
    build_exp();
    got = 0; first_word = -1;
    out_rdy = !stall;
    drive_pix(N, 0);
    if (stall) begin
      tick;
      chk("in_rdy_full", in_rdy, 0);
      for (int i = 0; i < 20; i++) begin
        tick;
        chk("stall_vld", out_vld, 1);
        chk("stall_data", out_data, exp_q[0]);
      end
      out_rdy = 1;
    end
    while (got < NW && k < 5000) begin tick; k++; end
    chk("words", got, NW);
    chk("first_word", first_word, fw);
    chk("queue_empty", exp_q.size(), 0);
    tick; tick;
    chk("done_vld", out_vld, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    longint m;
    int k;
    repeat (3) tick;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 0;
    tick;
    mode = 1;
    for (int c = 0; c < CH; c++) begin
      for (int t = 0; t < TAPS; t++) wm[c][t] = 1;
      wm[c][TAPS] = -4;
    end
    load_all();
    run_frame(0, (longint'(5) << AW) | 5);
    mode = 2;
    for (int t = 0; t < TAPS; t++) begin wm[0][t] = 1; wm[1][t] = 0; end
    wm[0][TAPS] = -20; wm[1][TAPS] = 3;
    load_all();
    run_frame(0, longint'(3) << AW);
    mode = 3;
    for (int t = 0; t < 8; t++) begin wm[0][t] = 1 << t; wm[1][t] = -(1 << t); end
    wm[0][8] = 0; wm[1][8] = 0; wm[0][TAPS] = 0; wm[1][TAPS] = 200;
    load_all();
    run_frame(1, (longint'(199) << AW) | 7);
    clr_pulse(0);
    out_rdy = 0; got = 0; exp_q.delete();
    drive_pix(60, 4);
    chk("pre_clr_vld", out_vld, 1);
    clr_pulse(1);
    chk("clr_hold_vld", out_vld, 0);
    chk("clr_in_rdy", in_rdy, 1);
    out_rdy = 1;
    drive_pix(28, 3);
    clr_pulse(1);
    chk("clr_win_vld", out_vld, 0);
    for (int i = 0; i < 8; i++) begin tick; chk("clr_idle_vld", out_vld, 0); end
    run_frame(0, (longint'(199) << AW) | 7);
    s_clr = 1; tick; s_clr = 0;
    for (int c = 0; c < 2; c++)
      for (int t = 0; t <= TAPS; t++) begin
        s_we = 1; s_ch = 1'(c); s_tap = 4'(t);
        s_data = c == 0 ? 9'd255 : (t == TAPS ? 9'h1fc : 9'd1);
        tick;
        s_we = 0;
      end
    s_in_vld = 1; s_din = 1;
    for (int i = 0; i < 4 * TAPS; i++) tick;
    s_in_vld = 0;
    chk("s_in_rdy_full", s_in_rdy, 0);
    s_out_rdy = 1;
    k = 0;
    while (!s_out_vld && k < 50) begin tick; k++; end
    chk("s_out_vld", s_out_vld, 1);
    m = 0;
    for (int t = 0; t < TAPS; t++) m = addm(m, 255, 10);
    m = addm(m, 255, 10);
`ifdef CONV_SAT_EN
    chk("model_pin_aw10", m, 511);
    chk("s_ch0", s_out_data[9:0], 511);
`else
    chk("model_pin_aw10", m, 502);
    chk("s_ch0", s_out_data[9:0], 502);
`endif
    chk("s_ch1", s_out_data[19:10], 5);
    tick;
    chk("s_frame_done", s_frame_done, 1);
    tick;
    chk("s_frame_done_end", s_frame_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
